// File: rtl/mapper_pkg.sv
// Shared types and constants for the ROM write capture block and the
// downstream PRG address mux.
package mapper_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_LOW_DEF     = 3;
  localparam int BANK_W          = 4;
  localparam int DATA_W          = 8;
  localparam int ABORT_W         = 4;
  localparam int CNT_W           = 4;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [ABORT_W-1:0] sat_inc(input logic [ABORT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage flop chain used to bring one asynchronous bit into the clk domain.
// The reset value is a parameter so control lines can idle high and data low.
module bit_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the chain; the last stage is the safe output
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops are always written with <= so every stage samples the
    // pre-edge value of its neighbour; = here would collapse the chain.
    if (!rst_n) chain <= {STAGES{RST_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rom_write_capture.sv
// Captures CPU writes into PRG ROM space (UNROM-style bank register).
// All bus inputs are synchronized with equal latency, a write must stay
// low for MIN_LOW clocks to qualify, and the data is committed when the
// chip select is released.
module rom_write_capture
  import mapper_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int MIN_LOW      = MIN_LOW_DEF,
  parameter bit BUS_CONFLICT = 1'b1
) (
  input  logic               clk,
  input  logic               Nrst,
  input  logic               Ncpu_rw,
  input  logic               Ncpu_rom_cs,
  input  logic [DATA_W-1:0]  cpu_d,
  input  logic [DATA_W-1:0]  prg_d,
  output logic               wr_stb,
  output logic [DATA_W-1:0]  wr_data,
  output logic [BANK_W-1:0]  bank,
  output logic [ABORT_W-1:0] abort_cnt
);

  // ---------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clk edge
  // ---------------------------------------------------------------------
  logic rst_n;

  bit_sync #(.STAGES(2), .RST_VAL(1'b0)) u_rst_sync (
    .clk  (clk),
    .rst_n(Nrst),
    .d    (1'b1),
    .q    (rst_n)
  );

  // ---------------------------------------------------------------------
  // Input synchronizers, one chain per bit, all the same depth
  // ---------------------------------------------------------------------
  logic              rw_s;
  logic              cs_s;
  logic [DATA_W-1:0] cpu_d_s;
  logic [DATA_W-1:0] prg_d_s;
  logic              primed;

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rw (
    .clk(clk), .rst_n(rst_n), .d(Ncpu_rw), .q(rw_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(Ncpu_rom_cs), .q(cs_s)
  );

  for (genvar i = 0; i < DATA_W; i++) begin : g_data_sync
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cpu (
      .clk(clk), .rst_n(rst_n), .d(cpu_d[i]), .q(cpu_d_s[i])
    );
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_prg (
      .clk(clk), .rst_n(rst_n), .d(prg_d[i]), .q(prg_d_s[i])
    );
  end

  // Goes high once the chains hold real bus samples rather than reset values
  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_primed (
    .clk(clk), .rst_n(rst_n), .d(1'b1), .q(primed)
  );

  // ---------------------------------------------------------------------
  // Decoded bus conditions
  // ---------------------------------------------------------------------
  logic              cs_low;
  logic              wr_low;
  logic [DATA_W-1:0] data_sel;

  assign cs_low   = ~cs_s;
  assign wr_low   = ~rw_s;
  assign data_sel = BUS_CONFLICT ? (cpu_d_s & prg_d_s) : cpu_d_s;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] qual_cnt;
  logic [CNT_W-1:0] qual_cnt_inc;
  logic             armed;

  logic cnt_load;
  logic cnt_inc;
  logic sample_load;
  logic abort_inc;
  logic capture;

  assign qual_cnt_inc = qual_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; a missing branch
    // would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (armed && cs_low && wr_low) state_nxt = QUAL;
      QUAL: begin
        if (!cs_low || !wr_low)                     state_nxt = IDLE;
        else if (qual_cnt_inc >= CNT_W'(MIN_LOW))   state_nxt = HOLD;
      end
      HOLD: begin
        if (!cs_low)      state_nxt = DONE;
        else if (!wr_low) state_nxt = IDLE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    sample_load = 1'b0;
    abort_inc   = 1'b0;
    capture     = 1'b0;
    wr_stb      = 1'b0;
    unique case (state)
      IDLE: cnt_load = armed && cs_low && wr_low;
      QUAL: begin
        cnt_inc     = cs_low && wr_low;
        sample_load = cs_low && wr_low;
        abort_inc   = cs_low && !wr_low;
      end
      HOLD: begin
        sample_load = cs_low && wr_low;
        abort_inc   = cs_low && !wr_low;
        capture     = !cs_low;
      end
      DONE: wr_stb = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] sample;

  // Qualify counter, sample register, committed outputs and abort counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_cnt  <= '0;
      sample    <= '0;
      wr_data   <= '0;
      bank      <= '0;
      abort_cnt <= '0;
    end else begin
      if (cnt_load)     qual_cnt  <= CNT_W'(1);
      else if (cnt_inc) qual_cnt  <= qual_cnt_inc;
      if (sample_load)  sample    <= data_sel;
      if (capture) begin
        wr_data <= sample;
        bank    <= sample[BANK_W-1:0];
      end
      if (abort_inc)    abort_cnt <= sat_inc(abort_cnt);
    end
  end

  // A low period already in progress at reset release is not accepted:
  // the block arms only after it has seen the select high from real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               armed <= 1'b0;
    else if (primed && cs_s)  armed <= 1'b1;
  end

endmodule

// File: tb/tb_rom_write_capture.sv
// Directed bench for rom_write_capture. Two instances share the bus: one
// with the bus-conflict AND, one without. Stimulus pushes expected write
// data into per-instance queues; monitors pop and compare on each strobe.
module tb_rom_write_capture;
  import mapper_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       Nrst;
  logic       Ncpu_rw;
  logic       Ncpu_rom_cs;
  logic [7:0] cpu_d;
  logic [7:0] prg_d;

  logic       wr_stb,  wr_stb_nc;
  logic [7:0] wr_data, wr_data_nc;
  logic [3:0] bank,    bank_nc;
  logic [3:0] abort_cnt, abort_cnt_nc;

  int vectors     = 0;
  int miscompares = 0;
  int stb_cnt     = 0;
  int stb_cnt_nc  = 0;
  int cyc         = 0;
  int rise_cyc    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q_nc[$];

  rom_write_capture #(.SYNC_STAGES(SYNC), .MIN_LOW(3), .BUS_CONFLICT(1'b1)) dut (
    .clk(clk), .Nrst(Nrst), .Ncpu_rw(Ncpu_rw), .Ncpu_rom_cs(Ncpu_rom_cs),
    .cpu_d(cpu_d), .prg_d(prg_d), .wr_stb(wr_stb), .wr_data(wr_data),
    .bank(bank), .abort_cnt(abort_cnt)
  );

  rom_write_capture #(.SYNC_STAGES(SYNC), .MIN_LOW(3), .BUS_CONFLICT(1'b0)) dut_nc (
    .clk(clk), .Nrst(Nrst), .Ncpu_rw(Ncpu_rw), .Ncpu_rom_cs(Ncpu_rom_cs),
    .cpu_d(cpu_d), .prg_d(prg_d), .wr_stb(wr_stb_nc), .wr_data(wr_data_nc),
    .bank(bank_nc), .abort_cnt(abort_cnt_nc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the bus-conflict instance
  always @(negedge clk) begin : mon_bc
    logic [7:0] e;
    if (wr_stb) begin
      stb_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_stb", {31'b0, wr_stb}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", {24'b0, wr_data}, {24'b0, e});
        check("bank", {28'b0, bank}, {28'b0, e[3:0]});
        check("latency", cyc - rise_cyc, SYNC + 1);
      end
    end
  end

  // Monitor for the no-conflict instance
  always @(negedge clk) begin : mon_nc
    logic [7:0] e;
    if (wr_stb_nc) begin
      stb_cnt_nc++;
      if (exp_q_nc.size() == 0) begin
        check("spurious_stb_nc", {31'b0, wr_stb_nc}, 32'd0);
      end else begin
        e = exp_q_nc.pop_front();
        check("wr_data_nc", {24'b0, wr_data_nc}, {24'b0, e});
        check("bank_nc", {28'b0, bank_nc}, {28'b0, e[3:0]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One bus access: select low for low_clks; if rw_rise > 0 the CPU
  // releases R/W that many clocks into the access. Then gap clocks idle.
  task automatic bus_cycle(input logic [7:0] d, input logic [7:0] p,
                           input int low_clks, input int rw_rise, input int gap);
    cpu_d       = d;
    prg_d       = p;
    Ncpu_rw     = 1'b0;
    Ncpu_rom_cs = 1'b0;
    for (int i = 0; i < low_clks; i++) begin
      if (rw_rise > 0 && i == rw_rise) Ncpu_rw = 1'b1;
      tick(1);
    end
    Ncpu_rom_cs = 1'b1;
    Ncpu_rw     = 1'b1;
    rise_cyc    = cyc;
    tick(gap);
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    Nrst        = 1'b0;
    Ncpu_rw     = 1'b1;
    Ncpu_rom_cs = 1'b1;
    cpu_d       = 8'h00;
    prg_d       = 8'h00;
    #23;

    // Reset values
    check("rst_wr_stb", {31'b0, wr_stb}, 32'd0);
    check("rst_wr_data", {24'b0, wr_data}, 32'h00);
    check("rst_bank", {28'b0, bank}, 32'h0);
    check("rst_abort", {28'b0, abort_cnt}, 32'h0);

    @(posedge clk); #2;
    Nrst = 1'b1;
    tick(8);

    // Plain write
    exp_q.push_back(8'h05);
    exp_q_nc.push_back(8'h05);
    bus_cycle(8'h05, 8'hFF, 10, 0, 6);
    check("t1_bank", {28'b0, bank}, 32'h5);
    check("t1_abort", {28'b0, abort_cnt}, 32'h0);
    check("t1_stb_count", stb_cnt, 1);

    // Bus conflict: ROM drives 06 against CPU 0F
    exp_q.push_back(8'h06);
    exp_q_nc.push_back(8'h0F);
    bus_cycle(8'h0F, 8'h06, 10, 0, 6);
    check("t2_bank", {28'b0, bank}, 32'h6);
    check("t2_bank_nc", {28'b0, bank_nc}, 32'hF);

    // Glitch: one clock low, no strobe, nothing changes
    base = stb_cnt;
    bus_cycle(8'h09, 8'hFF, 1, 0, 6);
    check("glitch_stb", stb_cnt - base, 0);
    check("glitch_bank", {28'b0, bank}, 32'h6);
    check("glitch_abort", {28'b0, abort_cnt}, 32'h0);

    // Abort: R/W released 5 clocks into a 10-clock select
    bus_cycle(8'h07, 8'hFF, 10, 5, 4);
    check("abort_one", {28'b0, abort_cnt}, 32'h1);
    check("abort_stb", stb_cnt - base, 0);
    for (int k = 1; k < 20; k++) bus_cycle(8'h07, 8'hFF, 10, 5, 4);
    check("abort_sat", {28'b0, abort_cnt}, 32'hF);
    check("abort_sat_nc", {28'b0, abort_cnt_nc}, 32'hF);
    check("abort_bank", {28'b0, bank}, 32'h6);

    // Reset in the middle of a qualified write of 0A
    base        = stb_cnt;
    cpu_d       = 8'h0A;
    prg_d       = 8'hFF;
    Ncpu_rw     = 1'b0;
    Ncpu_rom_cs = 1'b0;
    tick(7);
    Nrst = 1'b0;
    #3;
    check("mid_rst_bank", {28'b0, bank}, 32'h0);
    check("mid_rst_abort", {28'b0, abort_cnt}, 32'h0);
    tick(1);
    Nrst = 1'b1;
    tick(4);
    Ncpu_rom_cs = 1'b1;
    Ncpu_rw     = 1'b1;
    tick(10);
    check("post_rst_stb", stb_cnt - base, 0);
    check("post_rst_bank", {28'b0, bank}, 32'h0);

    exp_q.push_back(8'h03);
    exp_q_nc.push_back(8'h03);
    bus_cycle(8'h03, 8'hFF, 10, 0, 6);
    check("after_rst_bank", {28'b0, bank}, 32'h3);

    // Back-to-back with two clocks high between accesses
    base = stb_cnt;
    exp_q.push_back(8'h01);
    exp_q_nc.push_back(8'h01);
    bus_cycle(8'h01, 8'hFF, 6, 0, 2);
    exp_q.push_back(8'h02);
    exp_q_nc.push_back(8'h02);
    bus_cycle(8'h02, 8'hFF, 6, 0, 8);
    check("b2b_stb", stb_cnt - base, 2);
    check("b2b_bank", {28'b0, bank}, 32'h2);
    check("b2b_bank_nc", {28'b0, bank_nc}, 32'h2);

    // Read cycle: no activity
    base = stb_cnt;
    cpu_d       = 8'h0C;
    Ncpu_rw     = 1'b1;
    Ncpu_rom_cs = 1'b0;
    tick(10);
    Ncpu_rom_cs = 1'b1;
    tick(6);
    check("read_stb", stb_cnt - base, 0);
    check("read_bank", {28'b0, bank}, 32'h2);
    check("read_abort", {28'b0, abort_cnt}, 32'h0);

    // Everything expected was delivered
    check("total_stb", stb_cnt, 5);
    check("total_stb_nc", stb_cnt_nc, 5);
    check("queue_left", exp_q.size(), 0);
    check("queue_left_nc", exp_q_nc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_write_capture.md
ROM_WRITE_CAPTURE -- requirements
Module: rom_write_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for all CPU-bus inputs; legal range 2..3.
REQ-002 Parameter MIN_LOW, default 3: consecutive synchronized clocks Ncpu_rom_cs must be low before a cycle qualifies; legal range 1..7.
REQ-003 Parameter BUS_CONFLICT, default 1: 1 = captured data is cpu_d AND prg_d, as in the UNROM bus conflict; 0 = cpu_d only.
REQ-004 clk  input  1  system clock, at least 8x the CPU M2 frequency; the single clock of the block.
REQ-005 Nrst  input  1  reset, asynchronous, active-low.
REQ-006 Ncpu_rw  input  1  CPU read/write, low = write; asynchronous to clk.
REQ-007 Ncpu_rom_cs  input  1  PRG ROM select ($8000-$FFFF), active-low; asynchronous to clk.
REQ-008 cpu_d  input  8  CPU data bus; asynchronous to clk.
REQ-009 prg_d  input  8  PRG ROM data output at the written address; asynchronous to clk.
REQ-010 wr_stb  output  1  one-clock pulse per accepted ROM-space write.
REQ-011 wr_data  output  8  data of the last accepted write; valid when wr_stb is high and held until the next accepted write.
REQ-012 bank  output  4  registered bank number, bits [3:0] of wr_data, consumed by the downstream PRG address mux.
REQ-013 abort_cnt  output  4  saturating count of aborted write cycles, for debug.

Function
REQ-014 Ncpu_rw, Ncpu_rom_cs, cpu_d and prg_d shall each pass through SYNC_STAGES flops, giving equal latency on all four signals.
REQ-015 FSM states: IDLE, QUAL, HOLD, DONE.
REQ-016 IDLE -> QUAL when synced Ncpu_rom_cs = 0 and synced Ncpu_rw = 0; the qualify counter loads 1.
REQ-017 QUAL: each clock with both synced signals still low, the counter increments and the data sample register loads the synced data (per BUS_CONFLICT); counter = MIN_LOW -> HOLD.
REQ-018 QUAL: synced Ncpu_rom_cs high before MIN_LOW is reached -> IDLE; the cycle is treated as a glitch and abort_cnt is not changed.
REQ-019 QUAL or HOLD: synced Ncpu_rw high while Ncpu_rom_cs is still low -> IDLE; abort_cnt increments, saturating at 15.
REQ-020 HOLD: the sample register keeps loading each clock while both signals stay low; the first clock with synced Ncpu_rom_cs high -> DONE, with no load on that clock.
REQ-021 DONE lasts exactly one clock: wr_stb = 1, wr_data = sample register, bank = sample[3:0]; then -> IDLE.
REQ-022 Latency: wr_stb rises exactly SYNC_STAGES+1 clocks after the rising edge of raw Ncpu_rom_cs (+/-1 clock for synchronizer metastability resolution).
REQ-023 A new low on Ncpu_rom_cs during DONE shall be recognised on the next clock in IDLE; no write is lost between back-to-back accesses separated by at least 2 clocks high.
REQ-024 Read cycles (Ncpu_rw high throughout) shall never cause a state change or any output activity.
REQ-025 At most one wr_stb per Ncpu_rom_cs low period.

Reset
REQ-026 Nrst low shall asynchronously force: FSM to IDLE, all synchronizer flops to 1 for control and 0 for data, sample register = 0, wr_stb = 0, wr_data = 8'h00, bank = 4'h0, abort_cnt = 0.
REQ-027 Reset asserted mid-cycle (QUAL, HOLD or DONE) shall discard the pending write; after release, the first cycle accepted is the next full low period seen from IDLE.
REQ-028 Reset release shall be synchronous to clk through a 2-flop reset synchronizer inside the block.

Structure
REQ-029 Package mapper_pkg shall hold the FSM state typedef, the SYNC_STAGES and MIN_LOW defaults, and the BANK_W = 4 constant shared with the PRG address mux.
REQ-030 One sub-module, bit_sync (an N-stage flop chain with a reset value parameter), shall be instantiated per synchronized bit.

Verification
REQ-031 Write: cpu_d = 8'h05, prg_d = 8'hFF, Ncpu_rom_cs low for 10 clk, Nrst high -> one wr_stb, wr_data = 8'h05, bank = 4'h5, abort_cnt = 0.
REQ-032 Bus conflict: cpu_d = 8'h0F, prg_d = 8'h06, BUS_CONFLICT = 1 -> wr_data = 8'h06, bank = 4'h6; with BUS_CONFLICT = 0 -> 8'h0F.
REQ-033 Glitch: Ncpu_rom_cs low for 1 clk with Ncpu_rw low, MIN_LOW = 3 -> no wr_stb, bank unchanged, abort_cnt = 0.
REQ-034 Abort: Ncpu_rw rises 5 clk into a 10-clk Ncpu_rom_cs low period -> no wr_stb, abort_cnt = 1; 20 such cycles -> abort_cnt = 15.
REQ-035 Reset mid-HOLD: Nrst pulsed low during a write of 8'h0A -> bank = 4'h0, no wr_stb; the next write of 8'h03 -> bank = 4'h3.
REQ-036 Back-to-back: writes of 8'h01 then 8'h02, with 2 clk high between them -> exactly two wr_stb pulses, final bank = 4'h2.
